// File: rtl/core_mem_arbiter_pkg.sv
// Shared widths, limits and state encoding for the core memory arbiter.
package core_mem_arbiter_pkg;

  localparam int RW          = 16;
  localparam int I_SIZE      = 2 * RW;
  localparam int BUS_AW      = RW + 2;
  localparam int MAX_D_BURST = 4;
  localparam int D_CNT_W     = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_LO  = 2'd1,
    F_HI  = 2'd2,
    D_ACC = 2'd3
  } arb_state_e;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Fetch, data and external bus signals of the core memory arbiter.
interface core_mem_arbiter_if;
  import core_mem_arbiter_pkg::*;

  // instruction fetch port
  logic              i_f_req;
  logic [RW-1:0]     i_f_addr;
  logic              i_f_abort;
  logic [I_SIZE-1:0] o_f_data;
  logic              o_f_valid;

  // data port
  logic              i_d_req;
  logic              i_d_we;
  logic [RW-1:0]     i_d_addr;
  logic [RW-1:0]     i_d_wdata;
  logic [RW-1:0]     o_d_rdata;
  logic              o_d_ack;

  // external 16-bit memory bus
  logic              o_bus_req;
  logic              o_bus_we;
  logic [BUS_AW-1:0] o_bus_addr;
  logic [RW-1:0]     o_bus_wdata;
  logic [RW-1:0]     i_bus_rdata;
  logic              i_bus_ack;

  // arbiter view
  modport slave (
    input  i_f_req, i_f_addr, i_f_abort,
    output o_f_data, o_f_valid,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output o_d_rdata, o_d_ack,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
    input  i_bus_rdata, i_bus_ack
  );

  // core + memory environment view
  modport master (
    output i_f_req, i_f_addr, i_f_abort,
    input  o_f_data, o_f_valid,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  o_d_rdata, o_d_ack,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
    output i_bus_rdata, i_bus_ack
  );

endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one 16-bit memory bus between a two-beat instruction fetch port and a
// single-beat data port; data has priority, bounded by a starvation limit.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  core_mem_arbiter_if.slave bus
);

  localparam logic [D_CNT_W-1:0] D_BURST_LIMIT = D_CNT_W'(MAX_D_BURST);

  arb_state_e         state_reg;
  logic [D_CNT_W-1:0] d_burst_cnt_reg;
  logic               abort_flag_reg;
  logic [RW-1:0]      lo_reg;
  logic [RW-1:0]      f_addr_reg;

  logic f_want;
  logic d_grant;
  logic f_grant;

  // Arbitration only happens in IDLE; an aborted fetch request is not eligible.
  always_comb begin
    f_want  = bus.i_f_req & ~bus.i_f_abort;
    d_grant = 1'b0;
    f_grant = 1'b0;
    if (state_reg == IDLE) begin
      if (bus.i_d_req && !(f_want && (d_burst_cnt_reg >= D_BURST_LIMIT))) begin
        d_grant = 1'b1;
      end else if (f_want) begin
        f_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      d_burst_cnt_reg <= '0;
      abort_flag_reg  <= 1'b0;
      lo_reg          <= '0;
      f_addr_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (d_grant) begin
            state_reg <= D_ACC;
          end else if (f_grant) begin
            state_reg  <= F_LO;
            f_addr_reg <= bus.i_f_addr;
          end
        end
        F_LO: begin
          if (bus.i_bus_ack) begin
            state_reg <= F_HI;
            lo_reg    <= bus.i_bus_rdata;
          end
        end
        F_HI: begin
          if (bus.i_bus_ack) begin
            state_reg <= IDLE;
          end
        end
        D_ACC: begin
          if (bus.i_bus_ack) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Counts data grants that overtook a waiting fetch.
      if (!bus.i_f_req || f_grant) begin
        d_burst_cnt_reg <= '0;
      end else if (d_grant && (d_burst_cnt_reg < D_BURST_LIMIT)) begin
        d_burst_cnt_reg <= d_burst_cnt_reg + D_CNT_W'(1);
      end

      // A flushed fetch still runs both beats; only its result is dropped.
      if ((state_reg == F_HI || state_reg == D_ACC) && bus.i_bus_ack) begin
        abort_flag_reg <= 1'b0;
      end else if ((state_reg == F_LO || state_reg == F_HI) && bus.i_f_abort) begin
        abort_flag_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.o_bus_req   = (state_reg != IDLE);
    bus.o_bus_we    = 1'b0;
    bus.o_bus_addr  = '0;
    bus.o_bus_wdata = '0;
    bus.o_d_ack     = 1'b0;
    bus.o_d_rdata   = '0;
    bus.o_f_valid   = 1'b0;
    bus.o_f_data    = '0;
    case (state_reg)
      D_ACC: begin
        bus.o_bus_addr  = {2'b00, bus.i_d_addr};
        bus.o_bus_we    = bus.i_d_we;
        bus.o_bus_wdata = bus.i_d_wdata;
        if (bus.i_bus_ack) begin
          bus.o_d_ack   = 1'b1;
          bus.o_d_rdata = bus.i_bus_rdata;
        end
      end
      F_LO: begin
        bus.o_bus_addr = {1'b1, f_addr_reg, 1'b0};
      end
      F_HI: begin
        bus.o_bus_addr = {1'b1, f_addr_reg, 1'b1};
        if (bus.i_bus_ack) begin
          bus.o_f_valid = ~abort_flag_reg & ~bus.i_f_abort;
          bus.o_f_data  = {bus.i_bus_rdata, lo_reg};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed and randomized checks of core_mem_arbiter against a memory-level model.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic i_clk;
  logic i_rst;

  core_mem_arbiter_if bus();

  core_mem_arbiter dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave memory, and the bench's own expectation of memory contents
  logic [RW-1:0]     slv_mem [logic [BUS_AW-1:0]];
  logic [RW-1:0]     ref_mem [logic [BUS_AW-1:0]];
  logic [BUS_AW-1:0] log_addr[$];
  bit                log_we[$];
  int                slave_wait = 0;
  bit                force_ack = 0;
  int                f_valid_cnt = 0;
  int                d_ack_cnt = 0;

  function automatic logic [RW-1:0] bg(input logic [BUS_AW-1:0] a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1;
    return x[31:16];
  endfunction

  function automatic logic [RW-1:0] slv_rd(input logic [BUS_AW-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : bg(a);
  endfunction

  function automatic logic [RW-1:0] ref_rd(input logic [BUS_AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  // memory slave with programmable wait states
  initial begin
    int wait_ctr;
    wait_ctr = 0;
    bus.i_bus_ack   = 1'b0;
    bus.i_bus_rdata = '0;
    forever begin
      @(posedge i_clk);
      #2;
      bus.i_bus_ack   = 1'b0;
      bus.i_bus_rdata = '0;
      if (force_ack) begin
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 16'hDEAD;
        force_ack       = 1'b0;
      end else if (bus.o_bus_req === 1'b1) begin
        if (wait_ctr >= slave_wait) begin
          bus.i_bus_ack = 1'b1;
          wait_ctr      = 0;
          if (bus.o_bus_we === 1'b1) slv_mem[bus.o_bus_addr] = bus.o_bus_wdata;
          else bus.i_bus_rdata = slv_rd(bus.o_bus_addr);
          log_addr.push_back(bus.o_bus_addr);
          log_we.push_back(bus.o_bus_we === 1'b1);
        end else begin
          wait_ctr++;
        end
      end else begin
        wait_ctr = 0;
      end
    end
  end

  // pulse counters and bus stability while the slave is stalling
  initial begin
    logic              prev_req, prev_ack, prev_we;
    logic [BUS_AW-1:0] prev_addr;
    logic [RW-1:0]     prev_wdata;
    prev_req = 0; prev_ack = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge i_clk);
      if (bus.o_f_valid === 1'b1) f_valid_cnt++;
      if (bus.o_d_ack === 1'b1) d_ack_cnt++;
      if (bus.o_bus_req === 1'b1 && prev_req && !prev_ack)
        chk("bus_hold", {bus.o_bus_we, bus.o_bus_addr, bus.o_bus_wdata} === {prev_we, prev_addr, prev_wdata},
            64'({bus.o_bus_we, bus.o_bus_addr, bus.o_bus_wdata}), 64'({prev_we, prev_addr, prev_wdata}));
      prev_req   = (bus.o_bus_req === 1'b1);
      prev_ack   = (bus.i_bus_ack === 1'b1);
      prev_we    = bus.o_bus_we;
      prev_addr  = bus.o_bus_addr;
      prev_wdata = bus.o_bus_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
  endtask

  task automatic run_data(input bit we, input logic [RW-1:0] a, input logic [RW-1:0] wd, input int w);
    logic [BUS_AW-1:0] ba;
    logic [RW-1:0]     exp_rd, got_rd;
    int                lat, d0;
    bit                got;
    ba     = {2'b00, a};
    exp_rd = ref_rd(ba);
    slave_wait = w;
    clear_log();
    d0  = d_ack_cnt;
    got = 0; lat = -1; got_rd = '0;
    bus.i_d_req = 1'b1; bus.i_d_we = we; bus.i_d_addr = a; bus.i_d_wdata = wd;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge i_clk);
      if (bus.o_d_ack === 1'b1) begin
        got = 1; lat = c; got_rd = bus.o_d_rdata;
      end
      tick();
    end
    bus.i_d_req = 1'b0; bus.i_d_we = 1'b0;
    @(negedge i_clk);
    tick();
    chk("d_done", got === 1'b1, 64'(got), 64'(1));
    chk("d_latency", lat === 1 + w, 64'(lat), 64'(1 + w));
    if (!we) chk("d_rdata", got_rd === exp_rd, 64'(got_rd), 64'(exp_rd));
    if (we) ref_mem[ba] = wd;
    chk("d_ack_pulses", (d_ack_cnt - d0) === 1, 64'(d_ack_cnt - d0), 64'(1));
    chk("d_beats", log_addr.size() === 1, 64'(log_addr.size()), 64'(1));
    if (log_addr.size() > 0)
      chk("d_bus_addr", {log_we[0], log_addr[0]} === {we, ba}, 64'({log_we[0], log_addr[0]}), 64'({we, ba}));
    $display("data %s addr=%h wdata=%h rdata=%h wait=%0d lat=%0d", we ? "wr" : "rd", a, wd, got_rd, w, lat);
  endtask

  task automatic run_fetch(input logic [RW-1:0] a, input int w);
    logic [BUS_AW-1:0] lo_a, hi_a;
    logic [I_SIZE-1:0] exp_d, got_d;
    int                lat, f0;
    bit                got;
    lo_a  = {1'b1, a, 1'b0};
    hi_a  = {1'b1, a, 1'b1};
    exp_d = {ref_rd(hi_a), ref_rd(lo_a)};
    slave_wait = w;
    clear_log();
    f0  = f_valid_cnt;
    got = 0; lat = -1; got_d = '0;
    bus.i_f_req = 1'b1; bus.i_f_addr = a;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge i_clk);
      if (bus.o_f_valid === 1'b1) begin
        got = 1; lat = c; got_d = bus.o_f_data;
      end
      tick();
    end
    bus.i_f_req = 1'b0;
    @(negedge i_clk);
    tick();
    chk("f_done", got === 1'b1, 64'(got), 64'(1));
    chk("f_latency", lat === 2 + 2 * w, 64'(lat), 64'(2 + 2 * w));
    chk("f_data", got_d === exp_d, 64'(got_d), 64'(exp_d));
    chk("f_valid_pulses", (f_valid_cnt - f0) === 1, 64'(f_valid_cnt - f0), 64'(1));
    chk("f_beats", log_addr.size() === 2, 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) begin
      chk("f_lo_addr", {log_we[0], log_addr[0]} === {1'b0, lo_a}, 64'({log_we[0], log_addr[0]}), 64'({1'b0, lo_a}));
      chk("f_hi_addr", {log_we[1], log_addr[1]} === {1'b0, hi_a}, 64'({log_we[1], log_addr[1]}), 64'({1'b0, hi_a}));
    end
    $display("fetch addr=%h data=%h wait=%0d lat=%0d", a, got_d, w, lat);
  endtask

  initial begin
    logic [BUS_AW-1:0] exp_a;
    int                f0, d0;

    bus.i_f_req = 0; bus.i_f_addr = '0; bus.i_f_abort = 0;
    bus.i_d_req = 0; bus.i_d_we = 0; bus.i_d_addr = '0; bus.i_d_wdata = '0;
    i_rst = 1'b1;

    slv_mem[18'h00042] = 16'hBEEF; ref_mem[18'h00042] = 16'hBEEF;
    slv_mem[18'h20020] = 16'h1234; ref_mem[18'h20020] = 16'h1234;
    slv_mem[18'h20021] = 16'hABCD; ref_mem[18'h20021] = 16'hABCD;

    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("rst_bus_req", bus.o_bus_req === 1'b0, 64'(bus.o_bus_req), 64'(0));
    chk("rst_bus_we", bus.o_bus_we === 1'b0, 64'(bus.o_bus_we), 64'(0));
    chk("rst_bus_addr", bus.o_bus_addr === 18'h0, 64'(bus.o_bus_addr), 64'(0));
    chk("rst_bus_wdata", bus.o_bus_wdata === 16'h0, 64'(bus.o_bus_wdata), 64'(0));
    chk("rst_f_valid", bus.o_f_valid === 1'b0, 64'(bus.o_f_valid), 64'(0));
    chk("rst_f_data", bus.o_f_data === 32'h0, 64'(bus.o_f_data), 64'(0));
    chk("rst_d_ack", bus.o_d_ack === 1'b0, 64'(bus.o_d_ack), 64'(0));
    chk("rst_d_rdata", bus.o_d_rdata === 16'h0, 64'(bus.o_d_rdata), 64'(0));
    $display("reset released");
    tick();
    i_rst = 1'b0;
    tick();

    // lone data read and lone fetch, zero-wait slave
    run_data(1'b0, 16'h0042, 16'h0000, 0);
    run_fetch(16'h0010, 0);

    // both requesters held: 4 data grants, one 2-beat fetch, repeating
    slave_wait = 0;
    clear_log();
    f0 = f_valid_cnt; d0 = d_ack_cnt;
    bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 16'h0100;
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0200;
    for (int c = 0; c < 200 && log_addr.size() < 18; c++) begin
      @(negedge i_clk);
      tick();
    end
    bus.i_d_req = 1'b0; bus.i_f_req = 1'b0;
    tick();
    tick();
    chk("cont_beats", log_addr.size() === 18, 64'(log_addr.size()), 64'(18));
    for (int k = 0; k < 18; k++) begin
      if (k % 6 < 4)       exp_a = {2'b00, 16'h0100};
      else if (k % 6 == 4) exp_a = {1'b1, 16'h0200, 1'b0};
      else                 exp_a = {1'b1, 16'h0200, 1'b1};
      chk("cont_order", log_addr[k] === exp_a, 64'(log_addr[k]), 64'(exp_a));
    end
    chk("cont_f_valid", (f_valid_cnt - f0) === 3, 64'(f_valid_cnt - f0), 64'(3));
    chk("cont_d_ack", (d_ack_cnt - d0) === 12, 64'(d_ack_cnt - d0), 64'(12));
    $display("contention: %0d beats, %0d fetches, %0d data acks", log_addr.size(), f_valid_cnt - f0, d_ack_cnt - d0);

    // abort in IDLE drops that cycle's fetch request
    clear_log();
    bus.i_f_req = 1'b1; bus.i_f_abort = 1'b1; bus.i_f_addr = 16'h0033;
    tick();
    bus.i_f_req = 1'b0; bus.i_f_abort = 1'b0;
    repeat (3) tick();
    chk("idle_abort_beats", log_addr.size() === 0, 64'(log_addr.size()), 64'(0));
    $display("idle abort: beats=%0d", log_addr.size());

    // abort during the high beat with a 3-wait slave; address changes at the flush
    slave_wait = 3;
    clear_log();
    f0 = f_valid_cnt;
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0123;
    for (int c = 0; c < 64 && log_addr.size() < 1; c++) begin
      @(negedge i_clk);
      tick();
    end
    bus.i_f_abort = 1'b1; bus.i_f_req = 1'b0; bus.i_f_addr = 16'h7777;
    tick();
    bus.i_f_abort = 1'b0;
    for (int c = 0; c < 64 && log_addr.size() < 2; c++) begin
      @(negedge i_clk);
      tick();
    end
    @(negedge i_clk);
    chk("abort_idle_req", bus.o_bus_req === 1'b0, 64'(bus.o_bus_req), 64'(0));
    tick();
    chk("abort_beats", log_addr.size() === 2, 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) begin
      chk("abort_lo_addr", log_addr[0] === {1'b1, 16'h0123, 1'b0}, 64'(log_addr[0]), 64'({1'b1, 16'h0123, 1'b0}));
      chk("abort_hi_addr", log_addr[1] === {1'b1, 16'h0123, 1'b1}, 64'(log_addr[1]), 64'({1'b1, 16'h0123, 1'b1}));
    end
    chk("abort_no_valid", (f_valid_cnt - f0) === 0, 64'(f_valid_cnt - f0), 64'(0));
    $display("fetch abort in F_HI: beats=%0d valid=%0d", log_addr.size(), f_valid_cnt - f0);
    run_fetch(16'h0124, 1);

    // write held through 5 wait states, then read it back
    run_data(1'b1, 16'h0003, 16'h5555, 5);
    run_data(1'b0, 16'h0003, 16'h0000, 0);

    // reset while the low fetch beat is stalled
    slave_wait = 3;
    clear_log();
    f0 = f_valid_cnt; d0 = d_ack_cnt;
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0055;
    tick();
    @(negedge i_clk);
    chk("rst_mid_pre_req", bus.o_bus_req === 1'b1, 64'(bus.o_bus_req), 64'(1));
    tick();
    i_rst = 1'b1; bus.i_f_req = 1'b0;
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_req", bus.o_bus_req === 1'b0, 64'(bus.o_bus_req), 64'(0));
    tick();
    force_ack = 1'b1;
    @(negedge i_clk);
    chk("stray_ack_d_ack", bus.o_d_ack === 1'b0, 64'(bus.o_d_ack), 64'(0));
    chk("stray_ack_f_valid", bus.o_f_valid === 1'b0, 64'(bus.o_f_valid), 64'(0));
    chk("stray_ack_req", bus.o_bus_req === 1'b0, 64'(bus.o_bus_req), 64'(0));
    tick();
    @(negedge i_clk);
    chk("stray_ack_after_req", bus.o_bus_req === 1'b0, 64'(bus.o_bus_req), 64'(0));
    tick();
    chk("rst_mid_no_valid", (f_valid_cnt - f0) === 0, 64'(f_valid_cnt - f0), 64'(0));
    chk("rst_mid_no_dack", (d_ack_cnt - d0) === 0, 64'(d_ack_cnt - d0), 64'(0));
    chk("rst_mid_beats", log_addr.size() === 0, 64'(log_addr.size()), 64'(0));
    $display("reset in F_LO: stray ack ignored");

    // randomized serial traffic against the memory model
    for (int t = 0; t < 120; t++) begin
      int kind, w, gap;
      kind = int'($urandom_range(0, 2));
      w    = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      case (kind)
        0:       run_data(1'b0, 16'($urandom_range(0, 15)), 16'h0000, w);
        1:       run_data(1'b1, 16'($urandom_range(0, 15)), 16'($urandom), w);
        default: run_fetch(16'($urandom), w);
      endcase
      repeat (gap) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
